// File: rtl/prism_sequencer.sv
// prism_sequencer: execution stage behind the PRISM State Information Table.
// Each execute cycle it looks up the STEW for cur_state, evaluates one condition
// (synchronized input bit or loop-counter match), then registers the next state,
// the output byte, the loop counter and a one-cycle irq.
module prism_sequencer #(
  parameter int WIDTH   = 44,
  parameter int DEPTH   = 8,
  parameter int A_BITS  = 3,
  parameter int IN_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         debug_addr,
  input  logic               debug_wr,
  input  logic [31:0]        debug_wdata,
  output logic [31:0]        debug_rdata,
  input  logic [IN_BITS-1:0] in_data,
  output logic [A_BITS-1:0]  sit_raddr,
  input  logic [WIDTH-1:0]   sit_rdata,
  output logic [7:0]         out_data,
  output logic               irq,
  output logic               running
);

  localparam int STATE_BITS = $clog2(DEPTH);

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h04;
  localparam logic [5:0] ADDR_SIT    = 6'h10;

  logic [IN_BITS-1:0]    sync_meta;
  logic [IN_BITS-1:0]    sync_q;
  logic [STATE_BITS-1:0] cur_state;
  logic [7:0]            cnt;
  logic                  step_req;

  // STEW fields for the current state
  logic [2:0] ns_true;
  logic [2:0] ns_false;
  logic [2:0] cond_sel;
  logic       cond_inv;
  logic       cond_cnt;
  logic [1:0] cnt_op;
  logic [7:0] cnt_match;
  logic [7:0] out_true;
  logic [7:0] out_false;
  logic       irq_en;

  assign ns_true   = sit_rdata[2:0];
  assign ns_false  = sit_rdata[5:3];
  assign cond_sel  = sit_rdata[8:6];
  assign cond_inv  = sit_rdata[9];
  assign cond_cnt  = sit_rdata[10];
  assign cnt_op    = sit_rdata[12:11];
  assign cnt_match = sit_rdata[20:13];
  assign out_true  = sit_rdata[28:21];
  assign out_false = sit_rdata[36:29];
  assign irq_en    = sit_rdata[37];

  // Upper STEW bits belong to other consumers and are deliberately ignored here
  generate
    if (WIDTH > 38) begin : g_stew_hi
      logic unused_stew_hi;
      assign unused_stew_hi = ^sit_rdata[WIDTH-1:38];
    end
  endgenerate

  logic unused_wdata;
  assign unused_wdata = ^debug_wdata[31:3];

  logic ctrl_wr;
  logic state_rst;
  logic sit_wr;
  logic execute;
  logic cond_raw;
  logic cond;
  logic [7:0] cnt_next;

  assign ctrl_wr   = debug_wr && (debug_addr == ADDR_CTRL);
  assign state_rst = ctrl_wr && debug_wdata[2];
  assign sit_wr    = debug_wr && (debug_addr == ADDR_SIT);
  assign execute   = running || step_req;
  assign sit_raddr = A_BITS'(cur_state);

  // Condition evaluation uses the counter value from before this cycle's update
  always_comb begin
    cond_raw = cond_cnt ? (cnt == cnt_match) : sync_q[cond_sel];
    cond     = cond_raw ^ cond_inv;
    cnt_next = cnt;
    case (cnt_op)
      2'b01:   cnt_next = cnt + 8'd1;
      2'b10:   cnt_next = 8'd0;
      default: cnt_next = cnt;
    endcase
  end

  // Two-flop synchronizer for the asynchronous condition inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= in_data;
      sync_q    <= sync_meta;
    end
  end

  // Sequencer datapath: state reset beats execute, idle cycles only drop irq
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= '0;
      cnt       <= '0;
      out_data  <= '0;
      irq       <= 1'b0;
    end else if (state_rst) begin
      cur_state <= '0;
      cnt       <= '0;
      out_data  <= '0;
      irq       <= 1'b0;
    end else if (execute) begin
      cur_state <= cond ? ns_true : ns_false;
      out_data  <= cond ? out_true : out_false;
      irq       <= cond && irq_en;
      cnt       <= cnt_next;
    end else begin
      irq       <= 1'b0;
    end
  end

  // Run/step control: loading the SIT halts the block, a step is a one-cycle request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running  <= 1'b0;
      step_req <= 1'b0;
    end else begin
      if (sit_wr) begin
        running <= 1'b0;
      end else if (ctrl_wr && debug_wdata[0]) begin
        running <= 1'b1;
      end
      step_req <= ctrl_wr && debug_wdata[1] && !debug_wdata[2] && !running;
    end
  end

  // Readback for the two owned addresses, zero elsewhere so it can be ORed upstream
  always_comb begin
    debug_rdata = 32'd0;
    case (debug_addr)
      ADDR_CTRL:   debug_rdata = {31'd0, running};
      ADDR_STATUS: debug_rdata = {7'd0, running, out_data, cnt, 5'd0, 3'(cur_state)};
      default:     debug_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_prism_sequencer.sv
// tb_prism_sequencer: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the sequencer and a small SIT memory.
module tb_prism_sequencer;

  localparam int WIDTH = 44;
  localparam logic [5:0] A_CTRL = 6'h00;
  localparam logic [5:0] A_STAT = 6'h04;
  localparam logic [5:0] A_SIT  = 6'h10;
  localparam logic [5:0] A_MEM  = 6'h14;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       debug_addr;
  logic             debug_wr;
  logic [31:0]      debug_wdata;
  logic [31:0]      debug_rdata;
  logic [7:0]       in_data;
  logic [2:0]       sit_raddr;
  logic [WIDTH-1:0] sit_rdata;
  logic [7:0]       out_data;
  logic             irq;
  logic             running;

  logic [WIDTH-1:0] sit_mem [8];

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int       m_state, m_cnt, m_out;
  bit       m_irq, m_run, m_step;
  bit [7:0] m_s1, m_s2;
  logic [5:0] rd_addr;

  prism_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .debug_addr  (debug_addr),
    .debug_wr    (debug_wr),
    .debug_wdata (debug_wdata),
    .debug_rdata (debug_rdata),
    .in_data     (in_data),
    .sit_raddr   (sit_raddr),
    .sit_rdata   (sit_rdata),
    .out_data    (out_data),
    .irq         (irq),
    .running     (running)
  );

  always #5 clk = ~clk;

  // SIT stand-in: combinational lookup of the addressed STEW
  assign sit_rdata = sit_mem[sit_raddr];

  function automatic logic [WIDTH-1:0] stew(int nst, int nsf, int sel, bit inv, bit ccnt,
                                            int op, int match, int ot, int of, bit ie);
    longint unsigned v;
    v = longint'(nst % 8) + longint'(nsf % 8) * 8 + longint'(sel % 8) * 64
      + longint'(inv) * 512 + longint'(ccnt) * 1024 + longint'(op % 4) * 2048
      + longint'(match % 256) * 8192 + longint'(ot % 256) * (64'd1 << 21)
      + longint'(of % 256) * (64'd1 << 29) + longint'(ie) * (64'd1 << 37);
    return WIDTH'(v);
  endfunction

  task automatic modelReset();
    m_state = 0; m_cnt = 0; m_out = 0;
    m_irq = 0; m_run = 0; m_step = 0;
    m_s1 = 8'd0; m_s2 = 8'd0;
  endtask

  // One clock of the sequencer, from the documented field meanings
  task automatic modelStep(input bit wr, input logic [5:0] addr, input logic [31:0] wd,
                           input logic [7:0] din);
    longint unsigned v;
    int ns_t, ns_f, sel, op, match, ot, of;
    bit inv, ccnt, ie, hit, take, is_ctrl, srst, n_step, n_run;
    v     = longint'(sit_mem[m_state]);
    ns_t  = int'(v % 8);
    ns_f  = int'((v / 8) % 8);
    sel   = int'((v / 64) % 8);
    inv   = bit'((v / 512) % 2);
    ccnt  = bit'((v / 1024) % 2);
    op    = int'((v / 2048) % 4);
    match = int'((v / 8192) % 256);
    ot    = int'((v >> 21) % 256);
    of    = int'((v >> 29) % 256);
    ie    = bit'((v >> 37) % 2);
    is_ctrl = wr && (addr == A_CTRL);
    srst    = is_ctrl && wd[2];
    hit     = ccnt ? (m_cnt == match) : m_s2[sel];
    take    = (hit != inv);
    n_step  = is_ctrl && wd[1] && !wd[2] && !m_run;
    n_run   = m_run;
    if (wr && addr == A_SIT) n_run = 0;
    else if (is_ctrl && wd[0]) n_run = 1;
    if (srst) begin
      m_state = 0; m_cnt = 0; m_out = 0; m_irq = 0;
    end else if (m_run || m_step) begin
      m_state = take ? ns_t : ns_f;
      m_out   = take ? ot : of;
      m_irq   = take && ie;
      if (op == 1) m_cnt = (m_cnt + 1) % 256;
      else if (op == 2) m_cnt = 0;
    end else begin
      m_irq = 0;
    end
    m_step = n_step;
    m_run  = n_run;
    m_s2   = m_s1;
    m_s1   = din;
  endtask

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelStatus();
    return {7'd0, m_run, 8'(m_out), 8'(m_cnt), 5'd0, 3'(m_state)};
  endfunction

  // Compare every DUT output against the model
  task automatic checkOutput();
    logic [31:0] exp_rd;
    if (rd_addr == A_CTRL)      exp_rd = {31'd0, m_run};
    else if (rd_addr == A_STAT) exp_rd = modelStatus();
    else                        exp_rd = 32'd0;
    compareVal("sit_raddr", 32'(sit_raddr), 32'(m_state));
    compareVal("out_data", 32'(out_data), 32'(m_out));
    compareVal("irq", 32'(irq), 32'(m_irq));
    compareVal("running", 32'(running), 32'(m_run));
    compareVal("debug_rdata", debug_rdata, exp_rd);
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge
  task automatic applyStimulus(input bit wr, input logic [5:0] addr, input logic [31:0] wd,
                               input logic [7:0] din, input logic [5:0] raddr);
    debug_wr    = wr;
    debug_addr  = addr;
    debug_wdata = wd;
    in_data     = din;
    modelStep(wr, addr, wd, din);
    @(posedge clk);
    #1;
    debug_wr    = 1'b0;
    debug_wdata = 32'd0;
    debug_addr  = raddr;
    rd_addr     = raddr;
    #1;
    checkOutput();
  endtask

  task automatic idle(input logic [7:0] din);
    applyStimulus(1'b0, A_STAT, 32'd0, din, A_STAT);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] wd;
    logic [WIDTH-1:0] w;
    logic [5:0] ra;
    int r;

    for (int i = 0; i < 8; i++) sit_mem[i] = '0;
    rst = 1'b1;
    debug_wr = 1'b0; debug_addr = A_STAT; debug_wdata = 32'd0; in_data = 8'd0;
    rd_addr = A_STAT;
    modelReset();
    #2;
    compareVal("reset_status", debug_rdata, 32'h0000_0000);
    compareVal("reset_raddr", 32'(sit_raddr), 32'd0);
    compareVal("reset_irq", 32'(irq), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Input path through the synchronizer
    sit_mem[0] = stew(1, 0, 2, 0, 0, 0, 0, 'hA5, 'h11, 0);
    sit_mem[1] = stew(1, 1, 0, 0, 0, 0, 0, 'hA5, 'hA5, 0);
    applyStimulus(1'b1, A_CTRL, 32'd1, 8'd0, A_STAT);
    repeat (3) idle(8'd0);
    compareVal("in0_out", 32'(out_data), 32'h11);
    compareVal("in0_state", 32'(sit_raddr), 32'd0);
    idle(8'h04);
    idle(8'h04);
    compareVal("in_t2_state", 32'(sit_raddr), 32'd0);
    idle(8'h04);
    compareVal("in_t3_state", 32'(sit_raddr), 32'd1);
    compareVal("in_t3_out", 32'(out_data), 32'hA5);
    applyStimulus(1'b1, A_SIT, 32'd0, 8'h04, A_CTRL);
    compareVal("sit_halt_ctrl", debug_rdata, 32'd0);

    // State reset while halted
    applyStimulus(1'b1, A_CTRL, 32'd4, 8'd0, A_STAT);
    compareVal("srst_status", debug_rdata, 32'h0000_0000);

    // Counter loop with irq on the match
    sit_mem[0] = stew(1, 0, 0, 0, 1, 1, 5, 'h77, 'h33, 1);
    sit_mem[1] = stew(1, 1, 0, 0, 0, 0, 0, 'h77, 'h77, 0);
    applyStimulus(1'b1, A_CTRL, 32'd1, 8'd0, A_STAT);
    repeat (5) idle(8'd0);
    compareVal("loop5_status", debug_rdata, 32'h0133_0500);
    compareVal("loop5_irq", 32'(irq), 32'd0);
    idle(8'd0);
    compareVal("loop6_status", debug_rdata, 32'h0177_0601);
    compareVal("loop6_irq", 32'(irq), 32'd1);
    idle(8'd0);
    compareVal("loop7_irq", 32'(irq), 32'd0);
    compareVal("loop7_status", debug_rdata, 32'h0177_0601);

    // SIT load while running: this execute uses the old STEW, then halt
    sit_mem[1] = stew(2, 2, 0, 0, 0, 0, 0, 'h99, 'h99, 0);
    applyStimulus(1'b1, A_SIT, 32'd0, 8'd0, A_STAT);
    sit_mem[1] = stew(3, 3, 0, 0, 0, 0, 0, 'h55, 'h55, 0);
    sit_mem[2] = stew(4, 4, 0, 0, 0, 0, 0, 'h42, 'h42, 0);
    sit_mem[4] = '0;
    compareVal("sitwr_status", debug_rdata, 32'h0099_0602);
    idle(8'd0);
    compareVal("halted_status", debug_rdata, 32'h0099_0602);

    // Single step while halted
    applyStimulus(1'b1, A_CTRL, 32'd2, 8'd0, A_STAT);
    compareVal("step_pending", debug_rdata, 32'h0099_0602);
    idle(8'd0);
    compareVal("step_done", debug_rdata, 32'h0042_0604);
    idle(8'd0);
    compareVal("step_once", debug_rdata, 32'h0042_0604);

    // State reset priority while running, step ignored while running
    sit_mem[0] = stew(0, 0, 0, 0, 0, 1, 0, 'h10, 'h10, 0);
    applyStimulus(1'b1, A_CTRL, 32'd5, 8'd0, A_STAT);
    compareVal("run_srst", debug_rdata, 32'h0100_0000);
    repeat (3) idle(8'd0);
    compareVal("run_cnt3", debug_rdata, 32'h0110_0300);
    applyStimulus(1'b1, A_CTRL, 32'd5, 8'd0, A_STAT);
    compareVal("srst_prio", debug_rdata, 32'h0100_0000);
    idle(8'd0);
    compareVal("srst_continue", debug_rdata, 32'h0110_0100);
    applyStimulus(1'b1, A_CTRL, 32'd3, 8'd0, A_STAT);
    applyStimulus(1'b1, A_SIT, 32'd0, 8'd0, A_STAT);
    idle(8'd0);
    compareVal("no_step_leak", debug_rdata, 32'h0010_0300);

    // Asynchronous reset while irq is firing every cycle
    sit_mem[0] = stew(0, 0, 0, 1, 0, 1, 0, 'h5A, 'h00, 1);
    applyStimulus(1'b1, A_CTRL, 32'd1, 8'd0, A_STAT);
    repeat (2) idle(8'd0);
    compareVal("pre_rst_irq", 32'(irq), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    compareVal("arst_status", debug_rdata, 32'd0);
    compareVal("arst_out", 32'(out_data), 32'd0);
    compareVal("arst_irq", 32'(irq), 32'd0);
    compareVal("arst_run", 32'(running), 32'd0);
    modelReset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(8'd0);

    // Randomized traffic
    for (int i = 0; i < 8; i++) begin
      w = {12'($urandom), $urandom};
      if ($urandom_range(0, 1) == 1) w[20:13] = 8'($urandom_range(0, 6));
      sit_mem[i] = w;
    end
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 4))
        0:       ra = A_CTRL;
        1:       ra = A_SIT;
        2:       ra = A_MEM;
        3:       ra = 6'($urandom);
        default: ra = A_STAT;
      endcase
      if (r < 8) begin
        wd = 32'($urandom_range(0, 7));
        if (m_run) wd[0] = 1'b1;
        applyStimulus(1'b1, A_CTRL, wd, 8'($urandom), ra);
      end else if (r < 11) begin
        applyStimulus(1'b1, A_SIT, $urandom, 8'($urandom), ra);
        w = {12'($urandom), $urandom};
        if ($urandom_range(0, 1) == 1) w[20:13] = 8'($urandom_range(0, 6));
        sit_mem[$urandom_range(0, 7)] = w;
      end else if (r < 14) begin
        applyStimulus(1'b1, ($urandom_range(0, 1) == 1) ? A_MEM : A_STAT, $urandom,
                      8'($urandom), ra);
      end else begin
        applyStimulus(1'b0, A_STAT, 32'd0, 8'($urandom), ra);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prism_sequencer.md
Name: prism_sequencer

Overview:
- Execution stage that sits directly downstream of the PRISM shift-register State Information Table (SIT).
- Drives the SIT read address with the current state index and consumes the 44-bit State Execution Word (STEW) that comes back combinationally.
- Each run cycle it evaluates one condition, then registers the next state, an 8-bit output value, a loop counter and an irq pulse.
- Programmed and observed over the same 6-bit periph debug bus that loads the SIT.

Parameters:
- WIDTH, 44: STEW width. Must be ≥ 38.
- DEPTH, 8: number of states. Only 8 is supported; state fields are fixed at 3 bits.
- A_BITS, 3: SIT address width.
- IN_BITS, 8: width of the external condition input bus.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- debug_addr  in  6  periph address.
- debug_wr  in  1  active-high write strobe.
- debug_wdata  in  32  write data.
- debug_rdata  out  32  readback. It is 0 for addresses this block does not own, and is ORed with the SIT readback upstream.
- in_data  in  IN_BITS  asynchronous condition inputs.
- sit_raddr  out  A_BITS  SIT read address. Always equals cur_state.
- sit_rdata  in  WIDTH  STEW for cur_state, valid in the same cycle.
- out_data  out  8  registered output value.
- irq  out  1  one-cycle interrupt pulse.
- running  out  1  enable bit.

Behaviour:
- Reset: clk and rst as decided (one clock; reset asynchronous, active-high). While rst=1, all of the following are 0: cur_state, cnt[7:0], out_data, irq, running, both synchronizer stages.
- Input sync: in_data passes through a 2-flop synchronizer (sync[7:0]), so input-to-condition latency is 2 clk.
- STEW fields:
  - [2:0] ns_true
  - [5:3] ns_false
  - [8:6] cond_sel
  - [9] cond_inv
  - [10] cond_cnt
  - [12:11] cnt_op (00 hold, 01 inc, 10 clear, 11 hold)
  - [20:13] cnt_match
  - [28:21] out_true
  - [36:29] out_false
  - [37] irq_en
  - [WIDTH-1:38] ignored
- Condition: raw = cond_cnt ? (cnt == cnt_match) : sync[cond_sel]; cond = raw ^ cond_inv. Compare uses the pre-update cnt.
- Execute cycle: fires when running=1, or for exactly one cycle after a step request. On an execute cycle:
  - cur_state <= cond ? ns_true : ns_false
  - out_data <= cond ? out_true : out_false
  - irq <= cond & irq_en
  - cnt updates per cnt_op. Increment wraps 255 -> 0.
- Non-execute cycle: cur_state, cnt and out_data hold; irq <= 0. irq is never high for two consecutive cycles unless two consecutive execute cycles both assert it.
- CTRL, address 0x00, write:
  - bit0 sets running.
  - bit1 is step: it requests one execute cycle on the next clk and is ignored if running=1.
  - bit2 is state reset: on the next clk, cur_state=0, cnt=0, out_data=0, irq=0, and the step request is dropped.
  - State reset has priority over execute in the same cycle.
- CTRL read: debug_rdata = {31'b0, running}.
- STATUS, address 0x04, read-only: {7'b0, running, out_data, cnt, 5'b0, cur_state}. Writes are ignored.
- SIT write interaction: any debug_wr to 0x10 clears running on that clk edge. An execute cycle in that same cycle still completes using the pre-shift sit_rdata; afterwards the block is halted.
- Write to 0x14: no effect on this block.
- Self-loop (ns = cur_state): legal. Counter loops rely on it.
- Reset mid-operation: all state returns to the reset values immediately and asynchronously. No pulse appears on irq.

Test Plan:
- Reset, then read 0x04 -> 0x00000000. sit_raddr=0, irq=0.
- Input path: SIT[0] = {cond_sel=2, ns_true=1, ns_false=0, out_true=0xA5, out_false=0x11}. Write CTRL=1; drive in_data[2]=1 at cycle t -> cur_state=1 and out_data=0xA5 at t+3. With in_data[2]=0 instead -> state stays 0, out_data=0x11.
- Counter loop: state 0 = {cond_cnt=1, cnt_match=5, cnt_op=inc, ns_true=1, ns_false=0, irq_en=1}. Run -> the state 0→1 transition happens on the 6th execute cycle, with cnt=6 and irq high for exactly 1 cycle.
- Single step: halted, write CTRL=2 -> exactly one transition, running stays 0. Write CTRL=3 while running -> step ignored.
- State reset priority: running, write CTRL=5 -> the next cycle shows cur_state=0, cnt=0, out_data=0, with running=1 continuing from state 0.
- SIT load while running: debug_wr to 0x10 -> running=0 on the next cycle. The execute in that cycle used the old STEW. Assert rst mid-run -> all outputs 0 asynchronously.
